// File: rtl/wb_bram_pipe_pkg.sv
// Shared types and helpers for the pipelined Wishbone block-RAM slave.
package wb_pkg;

  localparam int unsigned WB_MAX_READ_LAT = 4;

  typedef struct packed {
    logic valid;
    logic err;
  } wb_resp_t;

  // Number of byte-offset bits dropped from a Wishbone byte address.
  function automatic int unsigned clog2_bytes(input int unsigned data_l);
    return $clog2(data_l);
  endfunction

endpackage

// File: rtl/wb_bram_pipe_if.sv
// Wishbone B4 pipelined bus bundle between interconnect (master) and wb_bram_pipe (slave).
interface wb_bram_pipe_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_L = 4
);
  localparam int unsigned DATA_W = DATA_L * 8;

  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_stall;
  logic              wb_ack;
  logic              wb_err;
  logic [ADDR_W-1:0] wb_adr;
  logic [DATA_W-1:0] wb_dat_w;
  logic [DATA_W-1:0] wb_dat_r;
  logic              wb_we;
  logic [DATA_L-1:0] wb_sel;

  modport master (
    output wb_cyc, wb_stb, wb_adr, wb_dat_w, wb_we, wb_sel,
    input  wb_stall, wb_ack, wb_err, wb_dat_r
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_adr, wb_dat_w, wb_we, wb_sel,
    output wb_stall, wb_ack, wb_err, wb_dat_r
  );

endinterface

// File: rtl/wb_bram_pipe_resp_pipe.sv
// Fixed-depth response shift register; a flush kills every in-flight response on the same edge.
module wb_resp_pipe
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  wb_resp_t entry,
  output wb_resp_t head
);

  wb_resp_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= entry;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign head = stage[DEPTH-1];

endmodule

// File: rtl/wb_bram_pipe.sv
// Pipelined Wishbone B4 slave in front of a synchronous block RAM with READ_LAT-cycle reads.
// Optional out-of-range error responses: define WB_BRAM_PIPE_RANGE_CHECK_EN.
module wb_bram_pipe
  import wb_pkg::*;
#(
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned DATA_L     = 4,
  parameter  int unsigned DEPTH_LOG2 = 12,
  parameter  int unsigned READ_LAT   = 1,
  localparam int unsigned DATA_W     = DATA_L * 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wb_bram_pipe_if.slave         wb,
  output logic [DEPTH_LOG2-1:0] bram_addr,
  output logic [DATA_W-1:0]     bram_data_w,
  input  logic [DATA_W-1:0]     bram_data_r,
  output logic                  bram_en,
  output logic [DATA_L-1:0]     bram_sel
);

  localparam int unsigned OFS = clog2_bytes(DATA_L);

  logic     req;
  logic     in_range;
  wb_resp_t entry;
  wb_resp_t head;
  logic     unused_adr;

  assign wb.wb_stall = 1'b0;
  assign req         = wb.wb_cyc & wb.wb_stb;

`ifdef WB_BRAM_PIPE_RANGE_CHECK_EN
  assign in_range = ~|wb.wb_adr[ADDR_W-1:DEPTH_LOG2+OFS];
`else
  assign in_range = 1'b1;
`endif

  // Byte-offset bits (and, without range checking, upper bits) are deliberately ignored.
  assign unused_adr = ^wb.wb_adr;

  assign bram_addr   = wb.wb_adr[OFS +: DEPTH_LOG2];
  assign bram_data_w = wb.wb_dat_w;
  assign bram_en     = req & in_range;
  assign bram_sel    = (req & wb.wb_we & in_range) ? wb.wb_sel : '0;

  assign entry.valid = req;
  assign entry.err   = req & ~in_range;

  wb_resp_pipe #(
    .DEPTH (READ_LAT)
  ) u_resp_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (~wb.wb_cyc),
    .entry (entry),
    .head  (head)
  );

  assign wb.wb_ack   = head.valid & ~head.err;
  assign wb.wb_dat_r = bram_data_r;

`ifdef WB_BRAM_PIPE_RANGE_CHECK_EN
  assign wb.wb_err = head.valid & head.err;
`else
  assign wb.wb_err = 1'b0;
`endif

endmodule

// File: doc/wb_bram_pipe.md
Name: wb_bram_pipe

Overview:
Pipelined Wishbone B4 slave that fronts a synchronous block RAM, generalising the single-cycle controller.
- Supports configurable data width, RAM depth and RAM read latency (1–4 cycles).
- Uses byte-addressed Wishbone and word-addressed RAM.
- Aborts in-flight acks when the cycle is dropped.
- Sits between the bus interconnect and a single_bram-style RAM with enable and byte write enable.

Parameters:
ADDR_W, 32, Wishbone byte-address width.
DATA_L, 4, data width in bytes (power of 2, 1..16); DATA_W = DATA_L*8.
DEPTH_LOG2, 12, RAM depth = 2**DEPTH_LOG2 words.
READ_LAT, 1, cycles from bram_en to valid bram_data_r (1..4).

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  synchronous reset, active low
bram_addr  out  DEPTH_LOG2  RAM word address
bram_data_w  out  DATA_W  RAM write data
bram_data_r  in  DATA_W  RAM read data, valid READ_LAT cycles after bram_en
bram_en  out  1  RAM enable
bram_sel  out  DATA_L  RAM byte write enables
wb_cyc  in  1  bus cycle
wb_stb  in  1  strobe
wb_stall  out  1  stall
wb_ack  out  1  acknowledge
wb_err  out  1  error (see Optional Feature)
wb_adr  in  ADDR_W  byte address
wb_dat_w  in  DATA_W  write data
wb_dat_r  out  DATA_W  read data
wb_we  in  1  write enable
wb_sel  in  DATA_L  byte selects

Behaviour:
- Reset: one clock, clk; synchronous, active-low reset rst_n. While rst_n=0 at a rising edge:
  - wb_ack, wb_err and all pipeline valid bits clear to 0.
  - wb_dat_r shows bram_data_r; it is don't-care when wb_ack=0.
- Accept: req = wb_cyc & wb_stb & ~wb_stall. wb_stall is tied to 0, so one request can be accepted per cycle.
- Address translation: word = wb_adr[DEPTH_LOG2+log2(DATA_L)-1 : log2(DATA_L)]. Low byte-offset bits are ignored.
- RAM drive (combinational from the bus):
  - bram_addr = word.
  - bram_data_w = wb_dat_w.
  - bram_en = req & in_range.
  - bram_sel = (req & wb_we & in_range) ? wb_sel : 0.
- Pipeline: shift registers of depth READ_LAT carry {valid, err}, with entry = {req, req & ~in_range}.
  - At stage READ_LAT, wb_ack = valid & ~err and wb_err = valid & err.
  - Latency is exactly READ_LAT cycles from accept to ack, for both reads and writes.
- Ordering: acks return in issue order. Back-to-back requests give back-to-back acks.
- Cycle abort: wb_cyc=0 in any cycle clears every valid bit in the same edge. No ack or err is issued for requests accepted before the drop, even if wb_cyc is reasserted immediately.
- Write data: a write is performed at the accept edge, and is not undone by an abort.
- Read-after-write to the same word in consecutive cycles returns the newly written data, provided the RAM is write-first. This is a RAM property and is not forwarded here.
- wb_ack and wb_err are never 1 simultaneously.
- Reset mid-operation: all outstanding responses are discarded. A RAM write already issued stands.

Optional Feature:
WB_BRAM_PIPE_RANGE_CHECK_EN
- Defined:
  - in_range = (wb_adr >> log2(DATA_L)) < 2**DEPTH_LOG2, i.e. the upper address bits are zero.
  - An out-of-range access gets bram_en=0 and no write, and wb_err pulses READ_LAT cycles later instead of wb_ack.
- Undefined:
  - in_range is constant 1, so upper address bits alias (wrap modulo depth).
  - wb_err is tied to 0.

Decomposition:
- Package wb_pkg holds:
  - function clog2_bytes(DATA_L);
  - typedef wb_resp_t (struct {valid, err});
  - constant WB_MAX_READ_LAT=4.
- One sub-module: wb_resp_pipe, a parametrised READ_LAT-deep shift register of wb_resp_t with a synchronous flush input (driven by ~wb_cyc).

Test Plan:
1. Reset and idle: rst_n=0 for 3 cycles, then idle → wb_ack=0, wb_err=0, bram_en=0 throughout.
2. Write and read at READ_LAT=2:
   - Write 0xDEADBEEF at adr 0x10 with sel=4'b1111, then read 0x10.
   - → bram_addr=4 on both; acks 2 cycles after each accept; read wb_dat_r=0xDEADBEEF.
3. Byte write: sel=4'b0100 with dat=0x00AA0000 to adr 0x10 holding 0xDEADBEEF → subsequent read returns 0xDEAABEEF.
4. Streaming: 8 back-to-back reads at adr 0x0..0x1C with READ_LAT=3 → 8 consecutive acks starting cycle 3, with data in address order.
5. Cycle abort: issue 2 reads, then drop wb_cyc for 1 cycle before their acks → zero acks observed; a following read acks normally after READ_LAT.
6. Range check (macro defined, DEPTH_LOG2=4, DATA_L=4): read at adr 0x40 → bram_en=0 and wb_err=1 after READ_LAT. Without the macro, the same read gives wb_ack=1 with the data of word 0.
